// File: rtl/text_scroll_ctrl_if.sv
// Overlay sequencer bus: frame pacing and enable in, overlay origin/visibility out.
interface text_scroll_ctrl_if;
    logic       frame_tick;
    logic       enable;
    logic [6:0] origin_x;
    logic [5:0] origin_y;
    logic       show;
    logic [2:0] state;

    // Driver side: the video timing / control block.
    modport master (
        output frame_tick,
        output enable,
        input  origin_x,
        input  origin_y,
        input  show,
        input  state
    );

    // Sequencer side.
    modport slave (
        input  frame_tick,
        input  enable,
        output origin_x,
        output origin_y,
        output show,
        output state
    );
endinterface

// File: rtl/text_scroll_ctrl.sv
// Frame-rate sequencer for the text overlay: slide-in, hold, diagonal bounce, blink.
// Steps once per frame_tick; all outputs are registered.
module text_scroll_ctrl #(
    parameter int unsigned TEXT_W_CELLS   = 47,
    parameter int unsigned TEXT_H_CELLS   = 9,
    parameter int unsigned SCREEN_W_CELLS = 80,
    parameter int unsigned SCREEN_H_CELLS = 60,
    parameter int unsigned HOME_X         = 18,
    parameter int unsigned HOME_Y         = 12,
    parameter int unsigned HOLD_FRAMES    = 120,
    parameter int unsigned STEP_DIV       = 2,
    parameter int unsigned BOUNCE_HITS    = 4,
    parameter int unsigned BLINK_FRAMES   = 64
) (
    input logic               clk,
    input logic               rst,
    text_scroll_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StSlideIn = 3'd1,
        StHold    = 3'd2,
        StBounce  = 3'd3,
        StBlink   = 3'd4
    } state_e;

    // Frame counter serves both HOLD and BLINK; at least 4 bits so the blink bit exists.
    localparam int unsigned FrameMax = (HOLD_FRAMES > BLINK_FRAMES) ? HOLD_FRAMES : BLINK_FRAMES;
    localparam int unsigned FrameRaw = $clog2(FrameMax + 1);
    localparam int unsigned FrameW   = (FrameRaw < 4) ? 4 : FrameRaw;
    localparam int unsigned StepW    = $clog2(STEP_DIV + 1);
    localparam int unsigned HitW     = $clog2(BOUNCE_HITS + 1);

    localparam logic [6:0]        ScreenW   = 7'(SCREEN_W_CELLS);
    localparam logic [6:0]        HomeX     = 7'(HOME_X);
    localparam logic [5:0]        HomeY     = 6'(HOME_Y);
    localparam logic [6:0]        MaxX      = 7'(SCREEN_W_CELLS - TEXT_W_CELLS);
    localparam logic [5:0]        MaxY      = 6'(SCREEN_H_CELLS - TEXT_H_CELLS);
    localparam logic [FrameW-1:0] HoldLast  = FrameW'(HOLD_FRAMES);
    localparam logic [FrameW-1:0] BlinkLast = FrameW'(BLINK_FRAMES);
    localparam logic [StepW-1:0]  StepLast  = StepW'(STEP_DIV);
    localparam logic [HitW-1:0]   HitLast   = HitW'(BOUNCE_HITS);

    state_e            state_q;
    logic [6:0]        ox_q;
    logic [5:0]        oy_q;
    logic              show_q;
    logic              dir_x_q;  // 1 = moving toward 0
    logic              dir_y_q;
    logic [FrameW-1:0] frame_q;
    logic [StepW-1:0]  step_q;
    logic [HitW-1:0]   hit_q;

    logic              refl_x;
    logic              refl_y;
    logic              ndir_x;
    logic              ndir_y;
    logic [6:0]        mv_x;
    logic [5:0]        mv_y;
    logic [6:0]        slide_x;
    logic [FrameW-1:0] frame_nxt;
    logic [StepW-1:0]  step_nxt;
    logic [HitW-1:0]   hit_nxt;

    // Candidate next values: one bounce move (reflect at the approached edge, then step by 1).
    always_comb begin
        refl_x    = dir_x_q ? (ox_q == 7'd0) : (ox_q == MaxX);
        refl_y    = dir_y_q ? (oy_q == 6'd0) : (oy_q == MaxY);
        ndir_x    = dir_x_q ^ refl_x;
        ndir_y    = dir_y_q ^ refl_y;
        mv_x      = ndir_x ? (ox_q - 7'd1) : (ox_q + 7'd1);
        mv_y      = ndir_y ? (oy_q - 6'd1) : (oy_q + 6'd1);
        slide_x   = ox_q - 7'd1;
        frame_nxt = frame_q + FrameW'(1);
        step_nxt  = step_q + StepW'(1);
        hit_nxt   = hit_q + HitW'(refl_x | refl_y);  // a corner counts once
    end

    // Animation FSM with registered outputs; reset and enable-low abort share the idle values.
    always_ff @(posedge clk) begin
        if (rst || !bus.enable) begin
            state_q <= StIdle;
            ox_q    <= HomeX;
            oy_q    <= HomeY;
            show_q  <= 1'b0;
            dir_x_q <= 1'b0;
            dir_y_q <= 1'b0;
            frame_q <= '0;
            step_q  <= '0;
            hit_q   <= '0;
        end else if (bus.frame_tick) begin
            unique case (state_q)
                StIdle: begin
                    state_q <= StSlideIn;
                    ox_q    <= ScreenW;
                    oy_q    <= HomeY;
                    show_q  <= 1'b1;
                end
                StSlideIn: begin
                    ox_q <= slide_x;
                    if (slide_x == HomeX) begin
                        state_q <= StHold;
                        frame_q <= '0;
                    end
                end
                StHold: begin
                    frame_q <= frame_nxt;
                    if (frame_nxt == HoldLast) begin
                        state_q <= StBounce;
                        dir_x_q <= 1'b0;
                        dir_y_q <= 1'b0;
                        step_q  <= '0;
                        hit_q   <= '0;
                    end
                end
                StBounce: begin
                    if (step_nxt == StepLast) begin
                        step_q  <= '0;
                        ox_q    <= mv_x;
                        oy_q    <= mv_y;
                        dir_x_q <= ndir_x;
                        dir_y_q <= ndir_y;
                        hit_q   <= hit_nxt;
                        if ((refl_x || refl_y) && (hit_nxt == HitLast)) begin
                            state_q <= StBlink;
                            frame_q <= '0;
                        end
                    end else begin
                        step_q <= step_nxt;
                    end
                end
                StBlink: begin
                    frame_q <= frame_nxt;
                    show_q  <= ~frame_nxt[3];
                    if (frame_nxt == BlinkLast) begin
                        state_q <= StSlideIn;
                        ox_q    <= ScreenW;
                        oy_q    <= HomeY;
                        show_q  <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.origin_x = ox_q;
    assign bus.origin_y = oy_q;
    assign bus.show     = show_q;
    assign bus.state    = state_q;

endmodule

// File: tb/tb_text_scroll_ctrl.sv
// Bench for text_scroll_ctrl: directed scenarios plus randomized run against a frame-level model.
module tb_text_scroll_ctrl;

    typedef struct packed {
        int sw; int sh; int tw; int th; int hx; int hy;
        int hold; int stepdiv; int nhits; int blink;
    } cfg_t;

    // phase: 0 idle, 1 slide, 2 hold, 3 bounce, 4 blink; n = ticks spent in phase
    typedef struct packed {
        int phase; int n; int moves; int hits; int x; int y; int show;
    } mdl_t;

    localparam cfg_t CA = '{sw: 80, sh: 60, tw: 47, th: 9, hx: 18, hy: 12,
                            hold: 120, stepdiv: 2, nhits: 4, blink: 64};
    localparam cfg_t CB = '{sw: 80, sh: 60, tw: 47, th: 9, hx: 33, hy: 51,
                            hold: 3, stepdiv: 3, nhits: 2, blink: 20};

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    mdl_t ma, mb;

    text_scroll_ctrl_if aif ();
    text_scroll_ctrl_if bif ();

    assign bif.frame_tick = aif.frame_tick;
    assign bif.enable     = aif.enable;

    text_scroll_ctrl u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (aif)
    );

    text_scroll_ctrl #(
        .HOME_X       (33),
        .HOME_Y       (51),
        .HOLD_FRAMES  (3),
        .STEP_DIV     (3),
        .BOUNCE_HITS  (2),
        .BLINK_FRAMES (20)
    ) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    always #5 clk = ~clk;

    // Position of a bouncing coordinate from its unfolded travel distance (triangle wave).
    function automatic int fold(int u, int m);
        int p;
        int f;
        p = 2 * m;
        f = u % p;
        return (f > m) ? (p - f) : f;
    endfunction

    function automatic mdl_t mdl_reset(cfg_t c);
        mdl_t r;
        r = '{phase: 0, n: 0, moves: 0, hits: 0, x: c.hx, y: c.hy, show: 0};
        return r;
    endfunction

    function automatic mdl_t mdl_step(cfg_t c, mdl_t m);
        mdl_t r;
        int   mx, my, ux, uy;
        bit   rx, ry;
        r  = m;
        mx = c.sw - c.tw;
        my = c.sh - c.th;
        case (m.phase)
            0: begin
                r.phase = 1; r.n = 0; r.x = c.sw; r.y = c.hy; r.show = 1;
            end
            1: begin
                r.n = m.n + 1;
                r.x = c.sw - r.n;
                if (r.x == c.hx) begin r.phase = 2; r.n = 0; end
            end
            2: begin
                r.n = m.n + 1;
                if (r.n == c.hold) begin
                    r.phase = 3; r.n = 0; r.moves = 0; r.hits = 0;
                end
            end
            3: begin
                r.n = m.n + 1;
                if (r.n % c.stepdiv == 0) begin
                    ux = c.hx + m.moves;
                    uy = c.hy + m.moves;
                    rx = (ux > 0) && (ux % mx == 0);
                    ry = (uy > 0) && (uy % my == 0);
                    r.moves = m.moves + 1;
                    r.x = fold(c.hx + r.moves, mx);
                    r.y = fold(c.hy + r.moves, my);
                    if (rx || ry) begin
                        r.hits = m.hits + 1;
                        if (r.hits == c.nhits) begin r.phase = 4; r.n = 0; end
                    end
                end
            end
            default: begin
                r.n = m.n + 1;
                r.show = ((r.n / 8) % 2 == 0) ? 1 : 0;
                if (r.n == c.blink) begin
                    r.phase = 1; r.n = 0; r.x = c.sw; r.y = c.hy; r.show = 1;
                end
            end
        endcase
        return r;
    endfunction

    // Reference model advances on the same edge the DUT samples its inputs.
    always @(posedge clk) begin
        if (rst || !aif.enable) begin
            ma <= mdl_reset(CA);
            mb <= mdl_reset(CB);
        end else if (aif.frame_tick) begin
            ma <= mdl_step(CA, ma);
            mb <= mdl_step(CB, mb);
        end
    end

    // One frame pulse followed by a few quiet cycles; returns on a negedge.
    task automatic pulse(input int gap);
        @(negedge clk);
        aif.frame_tick = 1'b1;
        @(negedge clk);
        aif.frame_tick = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic ticks(input int n);
        repeat (n) pulse($urandom_range(0, 2));
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        aif.enable = 1'b0;
        aif.frame_tick = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic logic [16:0] obs_a();
        return {aif.state, aif.origin_x, aif.origin_y, aif.show};
    endfunction

    function automatic logic [16:0] obs_b();
        return {bif.state, bif.origin_x, bif.origin_y, bif.show};
    endfunction

    task automatic test_reset();
        apply_reset();
        n_cmp++;
        if (obs_a() !== {3'd0, 7'd18, 6'd12, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_a: got %h want %h", obs_a(), {3'd0, 7'd18, 6'd12, 1'b0});
        end
        n_cmp++;
        if (obs_b() !== {3'd0, 7'd33, 6'd51, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_b: got %h want %h", obs_b(), {3'd0, 7'd33, 6'd51, 1'b0});
        end
    endtask

    task automatic test_corner();
        apply_reset();
        aif.enable = 1'b1;
        ticks(53);
        n_cmp++;
        if (obs_b() !== {3'd3, 7'd33, 6'd51, 1'b1}) begin
            n_bad++;
            $display("FAIL corner_pre: got %h want %h", obs_b(), {3'd3, 7'd33, 6'd51, 1'b1});
        end
        ticks(1);
        n_cmp++;
        if (obs_b() !== {3'd3, 7'd32, 6'd50, 1'b1}) begin
            n_bad++;
            $display("FAIL corner_move: got %h want %h", obs_b(), {3'd3, 7'd32, 6'd50, 1'b1});
        end
        apply_reset();
    endtask

    task automatic test_slide_in();
        aif.enable = 1'b1;
        ticks(1);
        n_cmp++;
        if (obs_a() !== {3'd1, 7'd80, 6'd12, 1'b1}) begin
            n_bad++;
            $display("FAIL slide_first: got %h want %h", obs_a(), {3'd1, 7'd80, 6'd12, 1'b1});
        end
        ticks(61);
        n_cmp++;
        if (obs_a() !== {3'd1, 7'd19, 6'd12, 1'b1}) begin
            n_bad++;
            $display("FAIL slide_61: got %h want %h", obs_a(), {3'd1, 7'd19, 6'd12, 1'b1});
        end
        ticks(1);
        n_cmp++;
        if (obs_a() !== {3'd2, 7'd18, 6'd12, 1'b1}) begin
            n_bad++;
            $display("FAIL slide_home: got %h want %h", obs_a(), {3'd2, 7'd18, 6'd12, 1'b1});
        end
    endtask

    task automatic test_hold();
        ticks(119);
        n_cmp++;
        if (obs_a() !== {3'd2, 7'd18, 6'd12, 1'b1}) begin
            n_bad++;
            $display("FAIL hold_119: got %h want %h", obs_a(), {3'd2, 7'd18, 6'd12, 1'b1});
        end
        ticks(1);
        n_cmp++;
        if (obs_a() !== {3'd3, 7'd18, 6'd12, 1'b1}) begin
            n_bad++;
            $display("FAIL hold_120: got %h want %h", obs_a(), {3'd3, 7'd18, 6'd12, 1'b1});
        end
    endtask

    task automatic test_bounce();
        ticks(30);
        n_cmp++;
        if (obs_a() !== {3'd3, 7'd33, 6'd27, 1'b1}) begin
            n_bad++;
            $display("FAIL bounce_30: got %h want %h", obs_a(), {3'd3, 7'd33, 6'd27, 1'b1});
        end
        ticks(1);
        n_cmp++;
        if (obs_a() !== {3'd3, 7'd33, 6'd27, 1'b1}) begin
            n_bad++;
            $display("FAIL bounce_div: got %h want %h", obs_a(), {3'd3, 7'd33, 6'd27, 1'b1});
        end
        ticks(1);
        n_cmp++;
        if (obs_a() !== {3'd3, 7'd32, 6'd28, 1'b1}) begin
            n_bad++;
            $display("FAIL bounce_reflect: got %h want %h", obs_a(), {3'd3, 7'd32, 6'd28, 1'b1});
        end
        // Hits land on moves 16 (x), 40 (y), 49 (x), 82 (x) -> BLINK on tick 164.
        ticks(131);
        n_cmp++;
        if (obs_a() !== {3'd3, 7'd33, 6'd9, 1'b1}) begin
            n_bad++;
            $display("FAIL bounce_163: got %h want %h", obs_a(), {3'd3, 7'd33, 6'd9, 1'b1});
        end
        ticks(1);
        n_cmp++;
        if (obs_a() !== {3'd4, 7'd32, 6'd8, 1'b1}) begin
            n_bad++;
            $display("FAIL bounce_to_blink: got %h want %h", obs_a(), {3'd4, 7'd32, 6'd8, 1'b1});
        end
    endtask

    task automatic test_blink();
        logic exp_show;
        for (int k = 1; k <= 16; k++) begin
            ticks(1);
            exp_show = (k < 8 || k == 16);
            n_cmp++;
            if (obs_a() !== {3'd4, 7'd32, 6'd8, exp_show}) begin
                n_bad++;
                $display("FAIL blink_tick%0d: got %h want %h", k, obs_a(),
                         {3'd4, 7'd32, 6'd8, exp_show});
            end
        end
        ticks(47);
        n_cmp++;
        if (obs_a() !== {3'd4, 7'd32, 6'd8, 1'b0}) begin
            n_bad++;
            $display("FAIL blink_63: got %h want %h", obs_a(), {3'd4, 7'd32, 6'd8, 1'b0});
        end
        ticks(1);
        n_cmp++;
        if (obs_a() !== {3'd1, 7'd80, 6'd12, 1'b1}) begin
            n_bad++;
            $display("FAIL blink_restart: got %h want %h", obs_a(), {3'd1, 7'd80, 6'd12, 1'b1});
        end
    endtask

    task automatic test_abort();
        ticks(62 + 120 + 10);
        n_cmp++;
        if (obs_a() !== {3'd3, 7'd23, 6'd17, 1'b1}) begin
            n_bad++;
            $display("FAIL abort_pre: got %h want %h", obs_a(), {3'd3, 7'd23, 6'd17, 1'b1});
        end
        @(negedge clk);
        aif.enable = 1'b0;
        aif.frame_tick = 1'b1;
        @(negedge clk);
        aif.frame_tick = 1'b0;
        n_cmp++;
        if (obs_a() !== {3'd0, 7'd18, 6'd12, 1'b0}) begin
            n_bad++;
            $display("FAIL abort_enable: got %h want %h", obs_a(), {3'd0, 7'd18, 6'd12, 1'b0});
        end
        // Ticks while disabled in IDLE change nothing.
        ticks(3);
        n_cmp++;
        if (obs_a() !== {3'd0, 7'd18, 6'd12, 1'b0}) begin
            n_bad++;
            $display("FAIL idle_disabled: got %h want %h", obs_a(), {3'd0, 7'd18, 6'd12, 1'b0});
        end
        aif.enable = 1'b1;
        ticks(5);
        n_cmp++;
        if (obs_a() !== {3'd1, 7'd76, 6'd12, 1'b1}) begin
            n_bad++;
            $display("FAIL abort_slide: got %h want %h", obs_a(), {3'd1, 7'd76, 6'd12, 1'b1});
        end
        @(negedge clk);
        rst = 1'b1;
        aif.frame_tick = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        aif.frame_tick = 1'b0;
        n_cmp++;
        if (obs_a() !== {3'd0, 7'd18, 6'd12, 1'b0}) begin
            n_bad++;
            $display("FAIL abort_rst: got %h want %h", obs_a(), {3'd0, 7'd18, 6'd12, 1'b0});
        end
    endtask

    task automatic test_back_to_back();
        logic [16:0] exp;
        @(negedge clk);
        aif.frame_tick = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            exp = {3'd1, 7'(80 - i), 6'd12, 1'b1};
            n_cmp++;
            if (obs_a() !== exp) begin
                n_bad++;
                $display("FAIL b2b_%0d: got %h want %h", i, obs_a(), exp);
            end
        end
        aif.frame_tick = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (obs_a() !== {3'd1, 7'd75, 6'd12, 1'b1}) begin
            n_bad++;
            $display("FAIL b2b_stable: got %h want %h", obs_a(), {3'd1, 7'd75, 6'd12, 1'b1});
        end
    endtask

    task automatic test_random();
        logic [16:0] exp_a, exp_b;
        int          bad_here;
        bad_here = 0;
        for (int c = 0; c < 30000; c++) begin
            @(negedge clk);
            exp_a = {3'(ma.phase), 7'(ma.x), 6'(ma.y), 1'(ma.show)};
            exp_b = {3'(mb.phase), 7'(mb.x), 6'(mb.y), 1'(mb.show)};
            n_cmp++;
            if (obs_a() !== exp_a) begin
                n_bad++;
                bad_here++;
                if (bad_here < 10)
                    $display("FAIL random_a cyc %0d: got %h want %h", c, obs_a(), exp_a);
            end
            n_cmp++;
            if (obs_b() !== exp_b) begin
                n_bad++;
                bad_here++;
                if (bad_here < 10)
                    $display("FAIL random_b cyc %0d: got %h want %h", c, obs_b(), exp_b);
            end
            rst            = ($urandom_range(0, 7999) == 0);
            aif.enable     = ($urandom_range(0, 3999) != 0);
            aif.frame_tick = ($urandom_range(0, 1) == 0);
        end
        rst = 1'b0;
        aif.frame_tick = 1'b0;
    endtask

    initial begin
        aif.enable = 1'b0;
        aif.frame_tick = 1'b0;
        test_reset();
        test_corner();
        test_slide_in();
        test_hold();
        test_bounce();
        test_blink();
        test_abort();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
